regwrite_arb: RTL and testbench



---
 rtl/regwrite_arb.sv | 78 +++++++
 tb/tb_regwrite_arb.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/regwrite_arb.sv
// rtl/regwrite_arb.sv - round-robin arbiter sharing the regfile write port between ALU and load writeback
// Optional write-in-flight bypass ports enabled by defining REGWRITE_ARB_FWD_EN.
module regwrite_arb #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [REGBITS-1:0] req0_addr,
  input  logic [WIDTH-1:0]   req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [REGBITS-1:0] req1_addr,
  input  logic [WIDTH-1:0]   req1_data,
  output logic               req1_ready,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd
`ifdef REGWRITE_ARB_FWD_EN
  ,
  input  logic [REGBITS-1:0] fwd_ra,
  output logic               fwd_hit,
  output logic [WIDTH-1:0]   fwd_data
`endif
);

  // prio names the requester that wins when both are valid
  logic               prio;
  logic               grant0;
  logic               grant1;
  logic               accept;
  logic [REGBITS-1:0] sel_addr;
  logic [WIDTH-1:0]   sel_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = req0_valid && (!req1_valid || !prio);
      grant1 = req1_valid && (!req0_valid ||  prio);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 || grant1;
  assign sel_addr   = grant1 ? req1_addr : req0_addr;
  assign sel_data   = grant1 ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio     <= 1'b0;
      regwrite <= 1'b0;
      wa       <= '0;
      wd       <= '0;
    end else begin
      regwrite <= 1'b0;
      if (accept) begin
        prio <= grant0;
        // writes to $0 consume their slot but never reach the regfile
        if (sel_addr != '0) begin
          regwrite <= 1'b1;
          wa       <= sel_addr;
          wd       <= sel_data;
        end
      end
    end
  end

`ifdef REGWRITE_ARB_FWD_EN
  always_comb begin
    fwd_hit  = regwrite && (wa == fwd_ra) && (fwd_ra != '0);
    fwd_data = fwd_hit ? wd : '0;
  end
`endif

endmodule

// File: tb/tb_regwrite_arb.sv
// tb/tb_regwrite_arb.sv - directed self-checking bench for regwrite_arb
module tb_regwrite_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        regwrite;
  logic [4:0]  wa;
  logic [31:0] wd;
`ifdef REGWRITE_ARB_FWD_EN
  logic [4:0]  fwd_ra;
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] rf [0:31];

  always #5 clk = ~clk;

  regwrite_arb #(.WIDTH(32), .REGBITS(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .regwrite(regwrite), .wa(wa), .wd(wd)
`ifdef REGWRITE_ARB_FWD_EN
    , .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  // regfile model fed by the write port
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (regwrite) begin
      rf[wa] <= wd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'h01; req0_data = 32'haa;
    req1_valid = 1'b1; req1_addr = 5'h02; req1_data = 32'hbb;
`ifdef REGWRITE_ARB_FWD_EN
    fwd_ra = 5'h00;
`endif
    #2;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready0", {31'b0, req0_ready}, 32'h0);
      check("rst_ready1", {31'b0, req1_ready}, 32'h0);
      step();
    end
    check("rst_regwrite", {31'b0, regwrite}, 32'h0);
    check("rst_wa", {27'b0, wa}, 32'h0);
    check("rst_wd", wd, 32'h0);

    // single requester 0
    reset = 1'b0;
    req1_valid = 1'b0;
    req0_addr = 5'h03; req0_data = 32'h14;
    #1;
    check("single_ready0", {31'b0, req0_ready}, 32'h1);
    check("single_ready1", {31'b0, req1_ready}, 32'h0);
    step();
    req0_valid = 1'b0;
    check("single_regwrite", {31'b0, regwrite}, 32'h1);
    check("single_wa", {27'b0, wa}, 32'h03);
    check("single_wd", wd, 32'h14);
    step();
    check("single_idle_regwrite", {31'b0, regwrite}, 32'h0);
    check("single_rf3", rf[3], 32'h14);

    // register 0 from requester 1 (also returns prio to 0)
    req1_valid = 1'b1; req1_addr = 5'h00; req1_data = 32'hff;
    #1;
    check("r0_ready1", {31'b0, req1_ready}, 32'h1);
    step();
    req1_valid = 1'b0;
    check("r0_regwrite", {31'b0, regwrite}, 32'h0);
    step();
    check("r0_rf0", rf[0], 32'h0);

    // contention: grants alternate 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'h04; req0_data = 32'h1d;
    req1_valid = 1'b1; req1_addr = 5'h05; req1_data = 32'h2a;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("cont_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      check("cont_ready1", {31'b0, req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      step();
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      check("cont_regwrite", {31'b0, regwrite}, 32'h1);
      check("cont_wa", {27'b0, wa}, (i % 2 == 0) ? 32'h04 : 32'h05);
      #1;
    end
    step();
    check("cont_end_regwrite", {31'b0, regwrite}, 32'h0);

    // same-address conflict
    req0_valid = 1'b1; req0_addr = 5'h07; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'h07; req1_data = 32'h22;
    #1;
    check("same_ready0", {31'b0, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0;
    #1;
    check("same_wd_first", wd, 32'h11);
    check("same_ready1", {31'b0, req1_ready}, 32'h1);
    step();
    req1_valid = 1'b0;
    check("same_regwrite2", {31'b0, regwrite}, 32'h1);
    check("same_wa2", {27'b0, wa}, 32'h07);
    check("same_wd_second", wd, 32'h22);
    step();
    check("same_rf7", rf[7], 32'h22);

`ifdef REGWRITE_ARB_FWD_EN
    req0_valid = 1'b1; req0_addr = 5'h09; req0_data = 32'h5a;
    step();
    req0_valid = 1'b0;
    fwd_ra = 5'h09;
    #1;
    check("fwd_hit", {31'b0, fwd_hit}, 32'h1);
    check("fwd_data", fwd_data, 32'h5a);
    fwd_ra = 5'h0a;
    #1;
    check("fwd_miss_hit", {31'b0, fwd_hit}, 32'h0);
    check("fwd_miss_data", fwd_data, 32'h0);
    step();
    fwd_ra = 5'h09;
    #1;
    check("fwd_idle_hit", {31'b0, fwd_hit}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
